// File: rtl/dft_pkg.sv
// -----------------------------------------------------------------------------
// dft_pkg
// Shared definitions for the JTAG-style test wrapper:
//   - tap_state_t : the 16 IEEE 1149.1 TAP controller states (standard codes)
//   - OP_*        : instruction opcodes (all-ones is BYPASS, undefined -> BYPASS)
//   - dr_sel_t    : which data register sits between tdi and tdo
//   - DEF_*_TAPS  : default LFSR / MISR feedback masks for the s9234_comb CUT
//   - tap_next()  : TAP next-state function
// -----------------------------------------------------------------------------
package dft_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [2:0] OP_INTEST  = 3'b000;
    localparam logic [2:0] OP_SAMPLE  = 3'b001;
    localparam logic [2:0] OP_RUNBIST = 3'b010;
    localparam logic [2:0] OP_READSIG = 3'b011;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_BOUNDARY,
        DR_SIGNATURE
    } dr_sel_t;

    localparam logic [35:0] DEF_LFSR_TAPS = 36'h8_0000_0C03;
    localparam logic [38:0] DEF_MISR_TAPS = 39'h40_0000_0011;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dft_tap_fsm.sv
// -----------------------------------------------------------------------------
// dft_tap_fsm
// IEEE 1149.1 TAP controller. One transition per rising clk, steered by tms.
// All outputs are registered from the next state, so each strobe is high for
// exactly the cycle the controller sits in the matching state.
// Ports:
//   clk, reset (async, active-low), tms
//   tlr        : in Test-Logic-Reset
//   capture_ir, shift_ir, update_ir : in Capture-IR / Shift-IR / Update-IR
//   capture_dr, shift_dr, update_dr : in Capture-DR / Shift-DR / Update-DR
//   rti_entry  : first cycle in Run-Test/Idle after arriving from another state
// -----------------------------------------------------------------------------
module dft_tap_fsm
    import dft_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic tms,
    output logic tlr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic rti_entry
);

    tap_state_t state;
    tap_state_t next_state;

    assign next_state = tap_next(state, tms);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= TEST_LOGIC_RESET;
            tlr        <= 1'b1;
            capture_ir <= 1'b0;
            shift_ir   <= 1'b0;
            update_ir  <= 1'b0;
            capture_dr <= 1'b0;
            shift_dr   <= 1'b0;
            update_dr  <= 1'b0;
            rti_entry  <= 1'b0;
        end else begin
            state      <= next_state;
            tlr        <= (next_state == TEST_LOGIC_RESET);
            capture_ir <= (next_state == CAPTURE_IR);
            shift_ir   <= (next_state == SHIFT_IR);
            update_ir  <= (next_state == UPDATE_IR);
            capture_dr <= (next_state == CAPTURE_DR);
            shift_dr   <= (next_state == SHIFT_DR);
            update_dr  <= (next_state == UPDATE_DR);
            // Only an arrival starts BIST; idling in RTI must not retrigger it.
            rti_entry  <= (next_state == RUN_TEST_IDLE) && (state != RUN_TEST_IDLE);
        end
    end

endmodule

// File: rtl/dft_bist_tap.sv
// -----------------------------------------------------------------------------
// dft_bist_tap
// JTAG-style test wrapper between chip pins and a combinational CUT, with an
// LFSR pattern generator / MISR compactor logic BIST engine.
// Ports:
//   clk (also TCK), reset (async, active-low)
//   tdi, tms, tdo            : test access port
//   func_in  [N_IN-1:0]      : functional inputs from pins
//   cut_in   [N_IN-1:0]      : drive to CUT inputs
//   cut_out  [N_OUT-1:0]     : CUT responses
//   func_out [N_OUT-1:0]     : functional outputs to pins
//   bist_busy / bist_done / bist_pass : BIST status (pass valid when done)
// -----------------------------------------------------------------------------
module dft_bist_tap
    import dft_pkg::*;
#(
    parameter int               N_IN        = 36,
    parameter int               N_OUT       = 39,
    parameter int               IR_W        = 3,
    parameter int               BIST_CYCLES = 1024,
    parameter logic [N_IN-1:0]  LFSR_TAPS   = N_IN'(DEF_LFSR_TAPS),
    parameter logic [N_IN-1:0]  SEED        = N_IN'(1),
    parameter logic [N_OUT-1:0] MISR_TAPS   = N_OUT'(DEF_MISR_TAPS),
    parameter logic [N_OUT-1:0] GOLDEN_SIG  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tdi,
    input  logic             tms,
    output logic             tdo,
    input  logic [N_IN-1:0]  func_in,
    output logic [N_IN-1:0]  cut_in,
    input  logic [N_OUT-1:0] cut_out,
    output logic [N_OUT-1:0] func_out,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass
);

    localparam int BSR_W = N_IN + N_OUT;
    localparam int SIG_W = N_OUT + 2;
    localparam int CNT_W = $clog2(BIST_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIST_CYCLES - 1);

    // TAP strobes
    logic tlr, capture_ir, shift_ir, update_ir;
    logic capture_dr, shift_dr, update_dr, rti_entry;

    logic [IR_W-1:0]  ir;
    logic [IR_W-1:0]  ir_shift;
    logic             bypass_reg;
    logic [BSR_W-1:0] bsr_shift;
    logic [BSR_W-1:0] bsr_update;
    logic [SIG_W-1:0] sig_shift;

    logic [N_IN-1:0]  lfsr;
    logic [N_OUT-1:0] misr;
    logic [N_OUT-1:0] misr_next;
    logic [CNT_W-1:0] count;
    logic             busy, done, pass;

    logic    is_intest, is_sample, is_runbist, is_readsig;
    dr_sel_t dr_sel;

    dft_tap_fsm u_tap (
        .clk        (clk),
        .reset      (reset),
        .tms        (tms),
        .tlr        (tlr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .rti_entry  (rti_entry)
    );

    // Fibonacci LFSR: shift towards MSB, parity of tapped bits enters at LSB.
    function automatic logic [N_IN-1:0] lfsr_step(input logic [N_IN-1:0] v);
        return {v[N_IN-2:0], ^(v & LFSR_TAPS)};
    endfunction

    // MISR uses the same register structure before the response is folded in.
    function automatic logic [N_OUT-1:0] misr_step(input logic [N_OUT-1:0] v);
        return {v[N_OUT-2:0], ^(v & MISR_TAPS)};
    endfunction

    // Undefined opcodes fall through to BYPASS because none of these match.
    assign is_intest  = (ir == IR_W'(OP_INTEST));
    assign is_sample  = (ir == IR_W'(OP_SAMPLE));
    assign is_runbist = (ir == IR_W'(OP_RUNBIST));
    assign is_readsig = (ir == IR_W'(OP_READSIG));

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (is_intest || is_sample) dr_sel = DR_BOUNDARY;
        else if (is_readsig)        dr_sel = DR_SIGNATURE;
    end

    // Instruction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir       <= '1;
            ir_shift <= '0;
        end else begin
            if (tlr)            ir <= '1;
            else if (update_ir) ir <= ir_shift;

            if (capture_ir)    ir_shift <= IR_W'(2'b01);
            else if (shift_ir) ir_shift <= {tdi, ir_shift[IR_W-1:1]};
        end
    end

    // Data registers: only the register selected by the IR captures/shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypass_reg <= 1'b0;
            bsr_shift  <= '0;
            bsr_update <= '0;
            sig_shift  <= '0;
        end else begin
            if (capture_dr) begin
                case (dr_sel)
                    DR_BOUNDARY:  bsr_shift  <= {cut_out, func_in};
                    DR_SIGNATURE: sig_shift  <= {pass, done, misr};
                    default:      bypass_reg <= 1'b0;
                endcase
            end else if (shift_dr) begin
                case (dr_sel)
                    DR_BOUNDARY:  bsr_shift  <= {tdi, bsr_shift[BSR_W-1:1]};
                    DR_SIGNATURE: sig_shift  <= {tdi, sig_shift[SIG_W-1:1]};
                    default:      bypass_reg <= tdi;
                endcase
            end

            if (update_dr && dr_sel == DR_BOUNDARY) bsr_update <= bsr_shift;
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (shift_ir) begin
            tdo = ir_shift[0];
        end else if (shift_dr) begin
            case (dr_sel)
                DR_BOUNDARY:  tdo = bsr_shift[0];
                DR_SIGNATURE: tdo = sig_shift[0];
                default:      tdo = bypass_reg;
            endcase
        end
    end

    // BIST engine. The CUT is combinational, so cut_out already reflects the
    // pattern on cut_in this cycle and is folded in on the same edge.
    assign misr_next = misr_step(misr) ^ cut_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr  <= SEED;
            misr  <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else if (busy && tlr) begin
            // Abort: status cleared, signature left for inspection.
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else if (busy) begin
            misr  <= misr_next;
            lfsr  <= lfsr_step(lfsr);
            count <= count + CNT_W'(1);
            if (count == LAST_COUNT) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (misr_next == GOLDEN_SIG);
            end
        end else if (rti_entry && is_runbist) begin
            lfsr  <= SEED;
            misr  <= '0;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
        end
    end

    // An all-zero LFSR would lock up and apply a constant pattern.
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!reset) lfsr != '0);

    assign cut_in    = busy ? lfsr : (is_intest ? bsr_update[N_IN-1:0] : func_in);
    assign func_out  = is_intest ? bsr_update[N_IN +: N_OUT] : cut_out;
    assign bist_busy = busy;
    assign bist_done = done;
    assign bist_pass = pass;

endmodule

// File: tb/tb_dft_bist_tap.sv
// -----------------------------------------------------------------------------
// tb_dft_bist_tap
// Directed bench for dft_bist_tap with an 8-pattern BIST. The CUT is modelled
// as a loopback (cut_out = {3'b0, cut_in}) during BIST, or as a constant
// response for boundary-scan checks. Expected LFSR patterns and the signature
// were worked out by hand for SEED=1 and the default feedback masks.
// -----------------------------------------------------------------------------
module tb_dft_bist_tap;

    localparam int N_IN  = 36;
    localparam int N_OUT = 39;

    logic             clk;
    logic             reset;
    logic             tdi;
    logic             tms;
    logic             tdo;
    logic [N_IN-1:0]  func_in;
    logic [N_IN-1:0]  cut_in;
    logic [N_OUT-1:0] cut_out;
    logic [N_OUT-1:0] func_out;
    logic             bist_busy;
    logic             bist_done;
    logic             bist_pass;

    logic             loopback;
    logic [N_OUT-1:0] cut_out_drv;

    int total;
    int bad;
    int busy_cycles;

    logic [127:0] dout;
    logic [127:0] exp_val;
    logic [74:0]  bsr_pat;
    logic [35:0]  lfsr_exp [8];

    assign cut_out = loopback ? {3'b000, cut_in} : cut_out_drv;

    dft_bist_tap #(
        .N_IN        (N_IN),
        .N_OUT       (N_OUT),
        .IR_W        (3),
        .BIST_CYCLES (8),
        .GOLDEN_SIG  (39'h1F)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tdi       (tdi),
        .tms       (tms),
        .tdo       (tdo),
        .func_in   (func_in),
        .cut_in    (cut_in),
        .cut_out   (cut_out),
        .func_out  (func_out),
        .bist_busy (bist_busy),
        .bist_done (bist_done),
        .bist_pass (bist_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TAP clock with the given tms; returns 1 time unit after the edge.
    task automatic tick(input logic t);
        tms = t;
        @(posedge clk);
        #1;
    endtask

    task automatic goto_shift_dr();   // from Run-Test/Idle
        tick(1'b1); tick(1'b0); tick(1'b0);
    endtask

    task automatic goto_shift_ir();   // from Run-Test/Idle
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    endtask

    task automatic exit_to_rti();     // from Exit1-xR via Update-xR
        tick(1'b1); tick(1'b0);
    endtask

    // Shift n bits LSB first; the last bit leaves the shift state.
    task automatic shift_bits(input logic [127:0] din, input int n, output logic [127:0] dq);
        dq = '0;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            #1;
            dq[i] = tdo;
            tick(i == n - 1);
        end
        tdi = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        lfsr_exp    = '{36'h1, 36'h3, 36'h6, 36'hD, 36'h1B, 36'h36, 36'h6D, 36'hDB};
        bsr_pat     = {39'h12_3456_789A, 36'hF_EDCB_A987};
        loopback    = 1'b0;
        cut_out_drv = 39'h0F_0000_00F0;
        func_in     = 36'h1_2345_6789;
        tdi         = 1'b0;
        tms         = 1'b1;
        reset       = 1'b0;

        // 1: reset state
        #12;
        check("rst_ir",       dut.ir, 3'b111);
        check("rst_tdo",      tdo, 1'b0);
        check("rst_busy",     bist_busy, 1'b0);
        check("rst_done",     bist_done, 1'b0);
        check("rst_pass",     bist_pass, 1'b0);
        check("rst_cut_in",   cut_in, 36'h1_2345_6789);
        check("rst_func_out", func_out, 39'h0F_0000_00F0);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1);
        tick(1'b1);
        check("tlr_ir", dut.ir, 3'b111);

        // 2: BYPASS, tdi 1,0,1,1 -> tdo 0,1,0,1
        tick(1'b0);
        goto_shift_dr();
        shift_bits(128'b1101, 4, dout);
        check("bypass_tdo", dout[3:0], 4'b1010);
        exit_to_rti();

        // 3: IR capture pattern then load SAMPLE
        goto_shift_ir();
        shift_bits(128'b001, 3, dout);
        check("ir_capture_tdo", dout[2:0], 3'b001);
        exit_to_rti();
        check("ir_sample", dut.ir, 3'b001);
        check("idle_tdo",  tdo, 1'b0);

        // 4: SAMPLE capture and shift; load a pattern into the update cells
        func_in     = 36'h9_ABCD_1234;
        cut_out_drv = 39'h55_AAAA_0F0F;
        #1;
        check("sample_cut_in",   cut_in, 36'h9_ABCD_1234);
        check("sample_func_out", func_out, 39'h55_AAAA_0F0F);
        goto_shift_dr();
        shift_bits({53'b0, bsr_pat}, 75, dout);
        exp_val = {53'b0, 39'h55_AAAA_0F0F, 36'h9_ABCD_1234};
        check("sample_shift", dout[74:0], exp_val);
        exit_to_rti();

        // INTEST drives the CUT and pins from the update cells
        goto_shift_ir();
        shift_bits(128'b000, 3, dout);
        exit_to_rti();
        check("intest_ir",       dut.ir, 3'b000);
        check("intest_cut_in",   cut_in, 36'hF_EDCB_A987);
        check("intest_func_out", func_out, 39'h12_3456_789A);

        // 5: RUNBIST with loopback CUT, signature 0x1F
        loopback = 1'b1;
        goto_shift_ir();
        shift_bits(128'b010, 3, dout);
        exit_to_rti();
        check("runbist_idle_busy", bist_busy, 1'b0);
        tick(1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 40 && bist_busy === 1'b1; i++) begin
            if (i < 8) check($sformatf("lfsr_pattern_%0d", i), cut_in, lfsr_exp[i]);
            busy_cycles++;
            tick(1'b0);
        end
        check("bist_busy_cycles", busy_cycles, 8);
        check("bist_end_busy",    bist_busy, 1'b0);
        check("bist_done",        bist_done, 1'b1);
        check("bist_pass",        bist_pass, 1'b1);
        tick(1'b0);
        check("bist_no_retrigger", bist_busy, 1'b0);

        // READSIG: MISR bits first, then done, then pass
        goto_shift_ir();
        shift_bits(128'b011, 3, dout);
        exit_to_rti();
        goto_shift_dr();
        shift_bits('0, 41, dout);
        exp_val = {87'b0, 1'b1, 1'b1, 39'h1F};
        check("readsig_shift", dout[40:0], exp_val);
        exit_to_rti();

        // 6: restart, then abort through Test-Logic-Reset
        goto_shift_ir();
        shift_bits(128'b010, 3, dout);
        exit_to_rti();
        check("restart_done_before", bist_done, 1'b1);
        tick(1'b0);
        check("restart_busy", bist_busy, 1'b1);
        check("restart_done", bist_done, 1'b0);
        repeat (4) tick(1'b0);
        repeat (5) tick(1'b1);
        check("abort_busy", bist_busy, 1'b0);
        check("abort_done", bist_done, 1'b0);
        check("abort_pass", bist_pass, 1'b0);
        check("abort_ir",   dut.ir, 3'b111);

        // Async reset in the middle of a run
        tick(1'b0);
        goto_shift_ir();
        shift_bits(128'b010, 3, dout);
        exit_to_rti();
        tick(1'b0);
        repeat (3) tick(1'b0);
        check("midrun_busy", bist_busy, 1'b1);
        func_in = 36'h5_0505_A0A0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy",   bist_busy, 1'b0);
        check("midrst_done",   bist_done, 1'b0);
        check("midrst_pass",   bist_pass, 1'b0);
        check("midrst_tdo",    tdo, 1'b0);
        check("midrst_ir",     dut.ir, 3'b111);
        check("midrst_cut_in", cut_in, 36'h5_0505_A0A0);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1);
        check("post_rst_busy", bist_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
